// File: rtl/gf180mcu_latbank_wrctl.sv
// Write sequencer and round-robin arbiter for a bank of RN-clearable level latches.
// Optional macro GF180MCU_LATBANK_WRCTL_HOLD_EN adds a data-hold cycle after each LE pulse.
module gf180mcu_latbank_wrctl #(
    parameter int NREQ    = 2,
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int DW      = 8,
    parameter int CLR_CYC = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*AW-1:0] ADDR,
    input  logic [NREQ*DW-1:0] WDATA,
    output logic [NREQ-1:0]    GNT,
    input  logic               CLR_REQ,
    output logic               CLR_DONE,
    output logic [DW-1:0]      LD,
    output logic [DEPTH-1:0]   LE,
    output logic               LRN,
    output logic               BUSY,
    output logic               ERR,
    output logic [2:0]         dbg_state
);
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW1 = PW + 1;
    localparam int AW1 = AW + 1;
    localparam int CW  = $clog2(CLR_CYC + 1);
    localparam logic [AW:0] DEPTH_V = AW1'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;

    // Handshake: a requester holds REQ/ADDR/WDATA stable until it sees GNT in
    // the same cycle; the payload is captured on the edge that ends that cycle.
    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, win;
    logic [PW:0]     idx;
    logic            any_req, take_write, addr_ok;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   clr_cnt;

    // Round-robin search starting at ptr, the index after the last winner.
    always_comb begin
        win     = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + PW1'(i);
            if (idx >= PW1'(NREQ)) idx = idx - PW1'(NREQ);
            if (!any_req && REQ[idx]) begin
                any_req = 1'b1;
                win     = idx[PW-1:0];
            end
        end
    end

    assign addr_ok = {1'b0, addr_q} < DEPTH_V;

    always_comb begin
        state_nxt  = state;
        take_write = 1'b0;
        GNT        = '0;
        case (state)
            S_IDLE: begin
                if (CLR_REQ) begin
                    state_nxt = S_CLEAR;
                end else if (any_req) begin
                    state_nxt  = S_SETUP;
                    take_write = 1'b1;
                    GNT        = RST ? '0 : ({{(NREQ-1){1'b0}}, 1'b1} << win);
                end
            end
            S_SETUP: state_nxt = S_PULSE;
`ifdef GF180MCU_LATBANK_WRCTL_HOLD_EN
            S_PULSE: state_nxt = S_HOLD;
`else
            S_PULSE: state_nxt = S_IDLE;
`endif
            S_HOLD:  state_nxt = S_IDLE;
            S_CLEAR: if (clr_cnt == CW'(CLR_CYC - 1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign BUSY      = (state != S_IDLE);
    assign ERR       = (state == S_PULSE) && !addr_ok;
    assign dbg_state = state;

    // LRN and LE are both decoded from state_nxt, so they can never overlap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            ptr      <= '0;
            addr_q   <= '0;
            clr_cnt  <= '0;
            LD       <= '0;
            LE       <= '0;
            LRN      <= 1'b0;
            CLR_DONE <= 1'b0;
        end else begin
            state    <= state_nxt;
            LRN      <= (state_nxt != S_CLEAR);
            LE       <= (state_nxt == S_PULSE && addr_ok) ?
                        ({{(DEPTH-1){1'b0}}, 1'b1} << addr_q) : '0;
            CLR_DONE <= (state == S_CLEAR) && (state_nxt == S_IDLE);
            clr_cnt  <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
            if (take_write) begin
                ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                addr_q <= ADDR[win*AW +: AW];
                LD     <= WDATA[win*DW +: DW];
            end
        end
    end
endmodule
